// File: rtl/reg_pkg.sv
// rtl/reg_pkg.sv - shared types and constants for the register bus master
package reg_pkg;

  // Default bus widths; the command payload below is sized by these, so a
  // wider bus needs these constants raised together with the top parameters.
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  // Register bus operation encoding as seen by the target.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } reg_op_e;

  // One queued command.
  typedef struct packed {
    logic                  write;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } reg_cmd_t;

endpackage

// File: rtl/reg_master_fifo.sv
// rtl/reg_master_fifo.sv - command queue between the command port and the bus FSM
module reg_master_fifo
  import reg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  reg_cmd_t wdata,
  input  logic     pop,
  output reg_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  reg_cmd_t      mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  // Guard against overflow/underflow; pointers wrap naturally since DEPTH is a power of 2.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/reg_master.sv
// rtl/reg_master.sv - queued register bus master, one transaction in flight
module reg_master
  import reg_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic [1:0]        reg_op,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e            state;
  state_e            next_state;
  reg_cmd_t          push_cmd;
  reg_cmd_t          head_cmd;
  reg_cmd_t          cur_cmd;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [2:0]        lat_cnt;
  logic [DATA_W-1:0] rdata_q;

  // No pass-through: a full queue refuses even when the head leaves this cycle.
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  // Pack the command port into the queue payload.
  always_comb begin
    push_cmd       = '0;
    push_cmd.write = cmd_write;
    push_cmd.addr  = ADDR_W_DEF'(cmd_addr);
    push_cmd.wdata = DATA_W_DEF'(cmd_wdata);
  end

  reg_master_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (full),
    .empty (empty)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state and bus/response outputs; everything idles at zero outside its state.
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    reg_op     = OP_IDLE;
    reg_addr   = '0;
    reg_wdata  = '0;
    rsp_valid  = 1'b0;
    rsp_write  = 1'b0;
    rsp_rdata  = '0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        reg_op   = cur_cmd.write ? OP_WRITE : OP_READ;
        reg_addr = ADDR_W'(cur_cmd.addr);
        if (cur_cmd.write) reg_wdata = DATA_W'(cur_cmd.wdata);
        next_state = cur_cmd.write ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (lat_cnt == 3'(RD_LAT)) next_state = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_write = cur_cmd.write;
        rsp_rdata = rdata_q;
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // In-flight command, read-latency counter and captured read data.
  // lat_cnt is 1 in the first WAIT cycle, so the capture lands exactly RD_LAT cycles after ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_cmd <= '0;
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      if (pop) begin
        cur_cmd <= head_cmd;
        rdata_q <= '0;
      end
      if (state == ST_ISSUE) begin
        lat_cnt <= 3'd1;
      end else if (state == ST_WAIT) begin
        if (lat_cnt == 3'(RD_LAT)) begin
          rdata_q <= reg_rdata;
          lat_cnt <= '0;
        end else begin
          lat_cnt <= lat_cnt + 3'd1;
        end
      end
    end
  end

endmodule
